// File: rtl/mul_seq_pkg.sv
// Shared types for the multiply request sequencer: FSM states, widths and FIFO entry.
// MUL_SIGNED_EN adds a per-request signed flag to the entry.
package mul_seq_pkg;

  localparam int OPERAND_W = 32;
  localparam int PRODUCT_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
`ifdef MUL_SIGNED_EN
    logic                 is_signed;
`endif
  } req_entry_t;

  // Two's-complement magnitude; -2^31 maps to 0x8000_0000.
  function automatic logic [OPERAND_W-1:0] magnitude(input logic [OPERAND_W-1:0] v);
    return v[OPERAND_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mul_req_fifo.sv
// Request FIFO for the multiply sequencer: power-of-two depth, head visible combinationally.
// Entry layout follows mul_seq_pkg::req_entry_t (wider when MUL_SIGNED_EN is defined).
module mul_req_fifo
  import mul_seq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  req_entry_t push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output req_entry_t head
);

  req_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap modulo DEPTH for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mul_request_sequencer.sv
// Issue stage for the 32x32 iterative multiplier: buffers requests, pulses start, holds product.
// Define MUL_SIGNED_EN to add the req_signed port and sign/magnitude handling.
module mul_request_sequencer
  import mul_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
`ifdef MUL_SIGNED_EN
  input  logic        req_signed,
`endif
  output logic        mul_valid_in,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_valid_out,
  input  logic [63:0] mul_r,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_r,
  output logic        busy,
  output logic        err_spurious
);

  state_e               state_q, state_d;
  logic [OPERAND_W-1:0] mul_a_q, mul_a_d;
  logic [OPERAND_W-1:0] mul_b_q, mul_b_d;
  logic                 mul_valid_in_q, mul_valid_in_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [PRODUCT_W-1:0] resp_r_q, resp_r_d;
  logic                 err_q, err_d;
`ifdef MUL_SIGNED_EN
  logic                 neg_q, neg_d;
`endif

  req_entry_t push_entry;
  req_entry_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       load;

  always_comb begin
    push_entry   = '0;
    push_entry.a = req_a;
    push_entry.b = req_b;
`ifdef MUL_SIGNED_EN
    push_entry.is_signed = req_signed;
`endif
  end

  mul_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid),
    .push_data (push_entry),
    .pop       (load),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  always_comb begin
    state_d        = state_q;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    mul_valid_in_d = 1'b0;
    resp_valid_d   = resp_valid_q;
    resp_r_d       = resp_r_q;
    err_d          = err_q;
    load           = 1'b0;
`ifdef MUL_SIGNED_EN
    neg_d          = neg_q;
`endif

    case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_valid_out) begin
`ifdef MUL_SIGNED_EN
          resp_r_d = neg_q ? (~mul_r + 1'b1) : mul_r;
`else
          resp_r_d = mul_r;
`endif
          resp_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          // Straight to ISSUE when work is queued, avoiding an IDLE bubble.
          if (!fifo_empty) load = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d        = ISSUE;
      mul_valid_in_d = 1'b1;
`ifdef MUL_SIGNED_EN
      mul_a_d = head.is_signed ? magnitude(head.a) : head.a;
      mul_b_d = head.is_signed ? magnitude(head.b) : head.b;
      neg_d   = head.is_signed && (head.a[OPERAND_W-1] ^ head.b[OPERAND_W-1]);
`else
      mul_a_d = head.a;
      mul_b_d = head.b;
`endif
    end

    if (mul_valid_out && (state_q != WAIT)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      mul_valid_in_q <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_r_q       <= '0;
      err_q          <= 1'b0;
`ifdef MUL_SIGNED_EN
      neg_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      mul_valid_in_q <= mul_valid_in_d;
      resp_valid_q   <= resp_valid_d;
      resp_r_q       <= resp_r_d;
      err_q          <= err_d;
`ifdef MUL_SIGNED_EN
      neg_q          <= neg_d;
`endif
    end
  end

  assign req_ready    = !fifo_full;
  assign mul_valid_in = mul_valid_in_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign resp_valid   = resp_valid_q;
  assign resp_r       = resp_r_q;
  assign err_spurious = err_q;
  assign busy         = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mul_request_sequencer.sv
// Directed bench for mul_request_sequencer; the multiplier is played by hand-driven done pulses.
// Define MUL_SIGNED_EN to also exercise the signed path.
module tb_mul_request_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
`ifdef MUL_SIGNED_EN
  logic        req_signed;
`endif
  logic        mul_valid_in;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_valid_out;
  logic [63:0] mul_r;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_r;
  logic        busy;
  logic        err_spurious;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul_request_sequencer #(.DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
`ifdef MUL_SIGNED_EN
    .req_signed    (req_signed),
`endif
    .mul_valid_in  (mul_valid_in),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_valid_out (mul_valid_out),
    .mul_r         (mul_r),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_r        (resp_r),
    .busy          (busy),
    .err_spurious  (err_spurious)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic done_pulse(input logic [63:0] prod);
    mul_valid_out = 1'b1;
    mul_r         = prod;
    step();
    mul_valid_out = 1'b0;
    mul_r         = '0;
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (!mul_valid_in && n < 8) begin
      step();
      n++;
    end
    check(tag, mul_valid_in, 1'b1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
    mul_valid_out = 1'b0; mul_r = '0; resp_ready = 1'b0;
`ifdef MUL_SIGNED_EN
    req_signed = 1'b0;
`endif
    step(); step();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_mul_valid_in", mul_valid_in, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_spurious, 1'b0);
    check("rst_mul_a", mul_a, 64'd0);
    check("rst_resp_r", resp_r, 64'd0);
    reset = 1'b0;
    step();

    // Single request: 3 * 5
    req_valid = 1'b1; req_a = 32'd3; req_b = 32'd5;
    step();
    req_valid = 1'b0;
    check("single_no_pulse_yet", mul_valid_in, 1'b0);
    check("single_busy", busy, 1'b1);
    step();
    check("single_pulse", mul_valid_in, 1'b1);
    check("single_mul_a", mul_a, 64'd3);
    check("single_mul_b", mul_b, 64'd5);
    step();
    check("single_pulse_one_cycle", mul_valid_in, 1'b0);
    step(); step();
    check("single_wait_a_stable", mul_a, 64'd3);
    done_pulse(64'd15);
    check("single_resp_valid", resp_valid, 1'b1);
    check("single_resp_r", resp_r, 64'd15);
    ack();
    check("single_resp_cleared", resp_valid, 1'b0);
    check("single_busy_drop", busy, 1'b0);

    // Fill: five pushes while the multiplier stalls
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_a = 32'(10 + i); req_b = 32'd2;
      step();
      if (i == 1) begin
        check("fill_first_issue", mul_valid_in, 1'b1);
        check("fill_first_a", mul_a, 64'd10);
      end
    end
    check("fill_full", req_ready, 1'b0);
    req_a = 32'd99;
    step(); step(); step();
    check("fill_sixth_held", req_ready, 1'b0);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        wait_issue($sformatf("fill_issue_%0d", i));
        check($sformatf("fill_a_%0d", i), mul_a, 64'(10 + i));
      end
      check($sformatf("fill_b_%0d", i), mul_b, 64'd2);
      step();
      done_pulse(64'((10 + i) * 2));
      check($sformatf("fill_resp_%0d", i), resp_r, 64'((10 + i) * 2));
      ack();
    end
    step();
    check("fill_drained_busy", busy, 1'b0);
    check("fill_no_extra", mul_valid_in, 1'b0);

    // Backpressure: product held, no new issue until release
    req_valid = 1'b1; req_a = 32'd7; req_b = 32'd6;
    step();
    req_a = 32'd8; req_b = 32'd9;
    step();
    req_valid = 1'b0;
    check("bp_first_issue", mul_valid_in, 1'b1);
    check("bp_first_a", mul_a, 64'd7);
    step();
    done_pulse(64'd42);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold_r_%0d", i), resp_r, 64'd42);
      check($sformatf("bp_hold_noissue_%0d", i), mul_valid_in, 1'b0);
      step();
    end
    check("bp_still_valid", resp_valid, 1'b1);
    ack();
    check("bp_next_issue", mul_valid_in, 1'b1);
    check("bp_next_a", mul_a, 64'd8);
    check("bp_next_b", mul_b, 64'd9);
    check("bp_resp_cleared", resp_valid, 1'b0);
    step();
    done_pulse(64'd72);
    check("bp_second_r", resp_r, 64'd72);
    ack();
    check("bp_idle", busy, 1'b0);

    // Spurious done while idle
    done_pulse(64'd123);
    check("spur_err", err_spurious, 1'b1);
    check("spur_no_resp", resp_valid, 1'b0);
    step(); step(); step();
    check("spur_sticky", err_spurious, 1'b1);

    // Reset while in WAIT with two requests queued
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_a = 32'(i + 1); req_b = 32'd4;
      step();
    end
    req_valid = 1'b0;
    check("rw_busy", busy, 1'b1);
    check("rw_wait_a", mul_a, 64'd1);
    reset = 1'b1;
    #2;
    check("rw_async_busy", busy, 1'b0);
    check("rw_async_ready", req_ready, 1'b1);
    check("rw_async_err", err_spurious, 1'b0);
    check("rw_async_mul_a", mul_a, 64'd0);
    check("rw_async_resp", resp_valid, 1'b0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rw_queue_gone_%0d", i), mul_valid_in, 1'b0);
    end
    check("rw_idle", busy, 1'b0);
    done_pulse(64'd4);
    check("rw_late_done_err", err_spurious, 1'b1);
    check("rw_late_done_noresp", resp_valid, 1'b0);

`ifdef MUL_SIGNED_EN
    // Signed: -3 * 7 = -21
    req_valid = 1'b1; req_a = 32'hFFFF_FFFD; req_b = 32'd7; req_signed = 1'b1;
    step();
    req_valid = 1'b0; req_signed = 1'b0;
    step();
    check("sgn_issue", mul_valid_in, 1'b1);
    check("sgn_mul_a", mul_a, 64'd3);
    check("sgn_mul_b", mul_b, 64'd7);
    step();
    done_pulse(64'd21);
    check("sgn_resp_r", resp_r, 64'hFFFF_FFFF_FFFF_FFEB);
    ack();
    // Most negative operand: -2^31 * -1 = +2^31
    req_valid = 1'b1; req_a = 32'h8000_0000; req_b = 32'hFFFF_FFFF; req_signed = 1'b1;
    step();
    req_valid = 1'b0; req_signed = 1'b0;
    step();
    check("sgn_min_a", mul_a, 64'h8000_0000);
    check("sgn_min_b", mul_b, 64'd1);
    step();
    done_pulse(64'h8000_0000);
    check("sgn_min_r", resp_r, 64'h8000_0000);
    ack();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
